// File: rtl/lc3b_fetch_pkg.sv
// lc3b_fetch_pkg: shared types for the LC-3b instruction fetch slice.
//   lc3b_word         16-bit datapath word used for every address/data bus
//   lc3b_fetch_state  fetch FSM state (IDLE, REQ, DONE) with fixed encodings
//   lc3b_align        clears bit 0 so a word address is always even
package lc3b_fetch_pkg;

  typedef logic [15:0] lc3b_word;

  // Fixed encodings kept visible so legacy code that compares raw state bits still works.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    DONE = ST_DONE
  } lc3b_fetch_state;

  function automatic lc3b_word lc3b_align(input lc3b_word w);
    return {w[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/lc3b_fetch_pc.sv
// lc3b_fetch_pc: program counter register for the fetch stage.
//   clk       system clock
//   rst_n     synchronous active-low reset, loads RESET_PC
//   load      load load_val (redirect or pending target); wins over inc
//   load_val  new PC value, bit 0 forced to 0
//   inc       advance PC by 2 (16-bit wrap)
//   pc        current PC, bit 0 always 0
module lc3b_fetch_pc
  import lc3b_fetch_pkg::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        inc,
  output logic [15:0] pc
);

  lc3b_word pc_q;
  lc3b_word pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = lc3b_align(load_val);
    end else if (inc) begin
      pc_d = pc_q + 16'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= lc3b_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/lc3b_fetch.sv
// lc3b_fetch: LC-3b instruction fetch stage feeding the IR.
//   clk, rst_n   clock and synchronous active-low reset
//   fetch_req    control FSM asks for the next instruction (sampled in IDLE)
//   redirect     load PC with redirect_pc (accepted in any state)
//   redirect_pc  branch/jump target, bit 0 ignored
//   mem_address  read address, always equal to pc
//   mem_read     read request, held until mem_resp
//   mem_resp     one-cycle memory completion pulse
//   mem_rdata    read data, valid with mem_resp
//   instr        last fetched instruction (IR data input)
//   load_ir      one-cycle IR load strobe
//   pc           address of next instruction to fetch
//   busy         high while a fetch is in REQ or DONE
module lc3b_fetch
  import lc3b_fetch_pkg::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] mem_address,
  output logic        mem_read,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic        load_ir,
  output logic [15:0] pc,
  output logic        busy
);

  lc3b_fetch_state state_q, state_d;
  logic            kill_q, kill_d;
  lc3b_word        pend_q, pend_d;
  lc3b_word        instr_q, instr_d;

  logic            pc_load;
  lc3b_word        pc_load_val;
  logic            pc_inc;

  lc3b_fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    pend_d      = pend_q;
    instr_d     = instr_q;
    pc_load     = 1'b0;
    pc_load_val = redirect_pc;
    pc_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        // Redirect takes priority over starting a fetch in the same cycle.
        if (redirect) begin
          pc_load = 1'b1;
        end else if (fetch_req) begin
          state_d = REQ;
        end
      end

      REQ: begin
        if (mem_resp) begin
          if (redirect) begin
            // Same-cycle target beats any older pending target; data dropped.
            pc_load = 1'b1;
            kill_d  = 1'b0;
            state_d = IDLE;
          end else if (kill_q) begin
            pc_load     = 1'b1;
            pc_load_val = pend_q;
            kill_d      = 1'b0;
            state_d     = IDLE;
          end else begin
            instr_d = mem_rdata;
            pc_inc  = 1'b1;
            state_d = DONE;
          end
        end else if (redirect) begin
          // Read stays outstanding at the old pc; target applied on completion.
          pend_d = lc3b_align(redirect_pc);
          kill_d = 1'b1;
        end
      end

      DONE: begin
        if (redirect) begin
          pc_load = 1'b1;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      pend_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
    end
  end

  assign mem_address = pc;
  assign mem_read    = (state_q == REQ);
  assign load_ir     = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign instr       = instr_q;

endmodule

// File: tb/tb_lc3b_fetch.sv
module tb_lc3b_fetch;

  localparam logic [15:0] RST_PC = 16'h3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] instr;
  logic        load_ir;
  logic [15:0] pc;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Transaction-level reference: an outstanding read, a pending IR strobe,
  // and an optional deferred branch target that squashes the outstanding read.
  bit          m_outstanding = 0;
  bit          m_strobe      = 0;
  bit          m_squash      = 0;
  logic [15:0] m_target      = '0;
  logic [15:0] m_pc          = '0;
  logic [15:0] m_instr       = '0;

  always #5 clk = ~clk;

  lc3b_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .load_ir     (load_ir),
    .pc          (pc),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [15:0] even_rpc;
    even_rpc = redirect_pc & 16'hFFFE;
    if (!rst_n) begin
      m_pc = RST_PC; m_outstanding = 0; m_strobe = 0; m_squash = 0; m_instr = '0;
    end else if (m_outstanding) begin
      if (mem_resp) begin
        m_outstanding = 0;
        if (redirect) begin
          m_pc = even_rpc; m_squash = 0;
        end else if (m_squash) begin
          m_pc = m_target; m_squash = 0;
        end else begin
          m_instr = mem_rdata; m_pc = m_pc + 16'd2; m_strobe = 1;
        end
      end else if (redirect) begin
        m_target = even_rpc; m_squash = 1;
      end
    end else if (m_strobe) begin
      m_strobe = 0;
      if (redirect) m_pc = even_rpc;
    end else begin
      if (redirect) m_pc = even_rpc;
      else if (fetch_req) m_outstanding = 1;
    end
  endtask

  task automatic step(input bit rn, input bit fr, input bit rd, input logic [15:0] rpc,
                      input bit rs, input logic [15:0] rdat);
    rst_n = rn; fetch_req = fr; redirect = rd; redirect_pc = rpc;
    mem_resp = rs; mem_rdata = rdat;
    @(posedge clk);
    model_edge();
    #1;
    chk("mem_read", {15'd0, mem_read}, {15'd0, m_outstanding});
    chk("load_ir", {15'd0, load_ir}, {15'd0, m_strobe});
    chk("busy", {15'd0, busy}, {15'd0, m_outstanding | m_strobe});
    chk("pc", pc, m_pc);
    chk("mem_address", mem_address, m_pc);
    chk("instr", instr, m_instr);
  endtask

  task automatic idle();
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
  endtask

  initial begin
    // Reset
    step(0, 0, 0, 16'h0000, 0, 16'h0000);
    step(0, 1, 0, 16'h0000, 1, 16'hAAAA);
    chk("rst_pc", pc, 16'h3000);
    chk("rst_mem_read", {15'd0, mem_read}, 16'd0);
    chk("rst_instr", instr, 16'h0000);

    // Basic fetch, memory answers on the 3rd REQ cycle
    step(1, 1, 0, 16'h0000, 0, 16'h0000);
    chk("req_mem_read", {15'd0, mem_read}, 16'd1);
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    step(1, 0, 0, 16'h0000, 1, 16'h1261);
    chk("basic_load_ir", {15'd0, load_ir}, 16'd1);
    chk("basic_instr", instr, 16'h1261);
    chk("basic_pc", pc, 16'h3002);
    idle();
    chk("basic_single_pulse", {15'd0, load_ir}, 16'd0);

    // Zero-wait memory: strobe exactly two edges after fetch_req is sampled
    step(1, 1, 0, 16'h0000, 0, 16'h0000);
    chk("zw_no_strobe_yet", {15'd0, load_ir}, 16'd0);
    step(1, 0, 0, 16'h0000, 1, 16'h2222);
    chk("zw_load_ir", {15'd0, load_ir}, 16'd1);
    chk("zw_pc", pc, 16'h3004);
    idle();

    // Redirect in IDLE beats fetch_req
    step(1, 1, 1, 16'h4001, 0, 16'h0000);
    chk("idle_redir_pc", pc, 16'h4000);
    chk("idle_redir_no_read", {15'd0, mem_read}, 16'd0);
    step(1, 1, 0, 16'h0000, 0, 16'h0000);
    chk("idle_redir_addr", mem_address, 16'h4000);
    step(1, 0, 0, 16'h0000, 1, 16'h1111);
    idle();

    // Redirect mid-REQ squashes the pending read
    step(1, 1, 0, 16'h0000, 0, 16'h0000);
    step(1, 0, 1, 16'h5000, 0, 16'h0000);
    chk("kill_addr_held", mem_address, 16'h4002);
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    step(1, 0, 0, 16'h0000, 1, 16'hDEAD);
    chk("kill_no_load_ir", {15'd0, load_ir}, 16'd0);
    chk("kill_instr", instr, 16'h1111);
    chk("kill_pc", pc, 16'h5000);
    chk("kill_idle", {15'd0, busy}, 16'd0);
    idle();

    // PC wrap
    step(1, 0, 1, 16'hFFFE, 0, 16'h0000);
    step(1, 1, 0, 16'h0000, 0, 16'h0000);
    step(1, 0, 0, 16'h0000, 1, 16'h3333);
    chk("wrap_pc", pc, 16'h0000);
    idle();

    // Reset during REQ; late response ignored
    step(1, 1, 0, 16'h0000, 0, 16'h0000);
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    step(0, 0, 0, 16'h0000, 0, 16'h0000);
    chk("rstreq_mem_read", {15'd0, mem_read}, 16'd0);
    chk("rstreq_pc", pc, RST_PC);
    step(1, 0, 0, 16'h0000, 1, 16'h4444);
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    chk("rstreq_no_load_ir", {15'd0, load_ir}, 16'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0),
           16'($urandom),
           ($urandom_range(0, 2) == 0),
           16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3b_fetch.md
# lc3b_fetch

Instruction fetch stage for the LC-3b core, directly upstream of the instruction register. On request from the control FSM it reads one 16-bit instruction from memory at the current PC, handles a multi-cycle memory handshake, and presents the instruction with a one-cycle load strobe for the IR. The PC advances by 2 after each completed fetch, and branch or jump redirects from the datapath are accepted at any time, including during an outstanding read.

## Interface
- RESET_PC, 16'h0000, PC value after reset; bit 0 ignored (forced 0)
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- fetch_req  in  1  control FSM requests next instruction; level, sampled in IDLE only
- redirect  in  1  load PC with redirect_pc (branch/JMP/JSR/TRAP target)
- redirect_pc  in  16 (lc3b_word)  new PC; bit 0 forced to 0 on load
- mem_address  out  16  read address; always equals pc
- mem_read  out  1  memory read request; held high until mem_resp
- mem_resp  in  1  memory completion, one-cycle pulse
- mem_rdata  in  16  read data, valid when mem_resp=1
- instr  out  16  last fetched instruction; feeds IR `in`
- load_ir  out  1  one-cycle strobe; drives IR `load`
- pc  out  16  address of the next instruction to fetch
- busy  out  1  high in REQ and DONE

## Operation
- States: IDLE, REQ, DONE. Encoded as lc3b_fetch_state.
- IDLE: mem_read=0. If redirect=1: pc <- {redirect_pc[15:1],0}, stay IDLE (redirect has priority over fetch_req the same cycle). Else if fetch_req=1: go REQ.
- REQ: mem_read=1, mem_address=pc. Wait any number of cycles for mem_resp.
  - redirect=1 while in REQ (mem_resp=0): latch target into pending register, set kill flag; mem_read stays high (transaction not abandoned).
  - mem_resp=1, no kill and no redirect this cycle: instr <- mem_rdata, pc <- pc+2, go DONE.
  - mem_resp=1 with kill set or redirect=1 this cycle: data discarded, instr unchanged, pc <- target (same-cycle redirect_pc wins over pending), clear kill, go IDLE; no load_ir.
- DONE: load_ir=1 for exactly this cycle, go IDLE. Redirect in DONE: pc <- redirect_pc; strobe still issued (instruction already valid).
- PC arithmetic: 16-bit modulo; 16'hFFFE+2 = 16'h0000. pc[0] is always 0.
- mem_rdata ignored when mem_resp=0 or outside REQ; spurious mem_resp in IDLE/DONE ignored.

## Timing
- Reset (rst_n=0 at posedge): state IDLE, pc=RESET_PC, mem_address=RESET_PC, mem_read=0, load_ir=0, instr=16'h0000, busy=0, kill cleared. Reset in REQ drops mem_read the following cycle.
- fetch_req sampled at edge t (IDLE) -> mem_read high from t+1.
- mem_resp at edge t+k -> DONE in cycle t+k+1: load_ir=1, instr valid, pc already incremented. IR captures at edge ending that cycle.
- Minimum fetch_req-to-load_ir latency: 2 cycles (mem_resp in first REQ cycle).
- Next fetch can start the cycle after DONE (fetch_req sampled in IDLE). Back-to-back throughput: one instruction per 3+ cycles.
- mem_address and mem_read are registered-state derived, glitch-free within cycle.

## Structure
- lc3b_types gains: lc3b_fetch_state enum {IDLE, REQ, DONE}; reuse lc3b_word for all 16-bit buses.
- One sub-module: lc3b_fetch_pc — PC register with synchronous active-low reset to RESET_PC, load (redirect/pending) and inc (+2) controls, load priority over inc, bit 0 forced 0.
- FSM, kill flag, pending target and instr register live in lc3b_fetch.

## Test plan
- Reset, RESET_PC=16'h3000: after reset pc=3000, mem_read=0; fetch_req, mem_resp after 3 cycles with data 16'h1261 -> load_ir single pulse, instr=1261, pc=3002.
- Zero-wait memory (mem_resp first REQ cycle) -> load_ir exactly 2 cycles after fetch_req sampled.
- Redirect in IDLE with fetch_req=1, redirect_pc=16'h4001 -> pc=4000, no mem_read that cycle; next fetch reads 4000.
- Redirect to 16'h5000 mid-REQ, mem_resp 2 cycles later with 16'hDEAD -> no load_ir, instr unchanged, pc=5000, state IDLE.
- pc=16'hFFFE, fetch completes -> pc=16'h0000.
- rst_n low during REQ -> mem_read low next cycle, pc=RESET_PC; later mem_resp ignored, no load_ir.
